warp_ready_table: RTL
=====================

WARP_READY_TABLE -- requirements
Module: warp_ready_table

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of warps tracked; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter PIPE_LAT, default 4, giving issue-to-ready cycles; legal range 1..8.
REQ-003 The block SHALL define local width COUNTW = $clog2(WIDTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port launch_valid, input, 1 bit: request to activate warp launch_warp.
REQ-007 The block SHALL have port launch_warp, input, COUNTW bits: index of the warp to activate.
REQ-008 The block SHALL have port issue_valid, input, 1 bit: the downstream arbiter issued a warp this cycle.
REQ-009 The block SHALL have port issue_oh, input, WIDTH bits: one-hot issued warp (the arbiter's grant_oh).
REQ-010 The block SHALL have port issue_is_mem, input, 1 bit: the issued instruction is a load and the warp waits for memory.
REQ-011 The block SHALL have port issue_is_exit, input, 1 bit: the issued instruction terminates the warp.
REQ-012 The block SHALL have port mem_done_valid, input, 1 bit: a memory response returned.
REQ-013 The block SHALL have port mem_done_warp, input, COUNTW bits: the warp owning that memory response.
REQ-014 The block SHALL have port req, output, WIDTH bits: per-warp ready vector; drives the arbiter req input.
REQ-015 The block SHALL have port active_count, output, COUNTW+1 bits: number of warps not INACTIVE.
REQ-016 The block SHALL have port all_idle, output, 1 bit: asserted when active_count == 0.
REQ-017 The block SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-018 Each warp SHALL hold a state: INACTIVE, READY, PIPE or MEM_WAIT; it SHALL also hold a 3-bit countdown and a 1-bit mem_pending flag.
REQ-019 req[i] SHALL be 1 iff warp i is READY; req SHALL decode from registered state only, with no combinational path from any input.
REQ-020 On launch_valid with warp launch_warp INACTIVE, that warp SHALL become READY at the next edge; a launch to a non-INACTIVE warp SHALL be ignored and SHALL set err.
REQ-021 An issue SHALL be accepted iff issue_valid=1, issue_oh is exactly one-hot and the target warp is READY.
REQ-022 issue_valid=1 with issue_oh=0 SHALL be a no-op, err unchanged.
REQ-023 issue_valid=1 with a multi-hot issue_oh, or with a one-hot target that is not READY, SHALL change no warp and SHALL set err.
REQ-024 An accepted issue with issue_is_exit=1 SHALL move the warp to INACTIVE; issue_is_exit SHALL take priority over issue_is_mem.
REQ-025 An accepted non-exit issue SHALL move the warp to PIPE with countdown = PIPE_LAT-1 and mem_pending = issue_is_mem.
REQ-026 A warp in PIPE SHALL decrement its countdown each cycle.
REQ-027 When a PIPE warp has countdown 0, it SHALL go to MEM_WAIT if mem_pending=1, else to READY.
REQ-028 Timing for a non-mem issue SHALL be: issue accepted in cycle t -> req[i]=0 in cycles t+1..t+PIPE_LAT -> req[i]=1 in cycle t+PIPE_LAT+1.
REQ-029 mem_done_valid for a MEM_WAIT warp SHALL move it to READY at the next edge.
REQ-030 mem_done_valid for a PIPE warp with mem_pending=1 SHALL clear mem_pending, so the warp exits PIPE directly to READY.
REQ-031 mem_done_valid for a warp in any other state SHALL be ignored and SHALL set err.
REQ-032 A launch, an issue and a mem_done arriving in the same cycle for different warps SHALL all take effect independently.
REQ-033 For the same warp in the same cycle, the state-legality rules above SHALL resolve the events: an issue needs READY and a launch needs INACTIVE, so at most one is legal; the illegal one sets err.
REQ-034 active_count SHALL be the population count of non-INACTIVE warps, decoded from registered state.
REQ-035 err SHALL stay set until reset.

Reset
REQ-036 While reset=1 at a rising edge, all warps SHALL go to INACTIVE and countdowns, mem_pending flags and err SHALL clear.
REQ-037 Reset SHALL override every other input in the same cycle.
REQ-038 After reset the outputs SHALL be req=0, active_count=0, all_idle=1, err=0.
REQ-039 Reset applied mid-operation (any warp in PIPE or MEM_WAIT) SHALL abandon all in-flight state; later mem_done inputs for those warps SHALL set err.

Verification
REQ-040 Scenario: reset, then launch warps 0 and 5 -> next cycle req=16'h0021, active_count=2, all_idle=0.
REQ-041 Scenario: with PIPE_LAT=4, issue warp 5 (non-mem) at cycle t -> req[5]=0 for t+1..t+4, req[5]=1 at t+5.
REQ-042 Scenario: issue warp 0 with is_mem=1, then mem_done at t+10 -> warp 0 is MEM_WAIT from t+5; req[0]=1 at t+11.
REQ-043 Scenario: issue warp 3 with is_mem=1, then mem_done at t+2 -> req[3]=1 at t+5 and err=0.
REQ-044 Scenario: issue_oh=16'h0003 with issue_valid=1 -> no state change, err=1; then issue warp 0 with is_exit -> active_count decrements, and all_idle=1 once the last warp exits.
REQ-045 Scenario: reset asserted while warp 2 is in PIPE -> next cycle req=0, active_count=0; a subsequent mem_done for warp 2 sets err.

Source files
------------

// File: rtl/warp_ready_table.sv
// -----------------------------------------------------------------------------
// warp_ready_table
//
// Purpose
//   Tracks the scheduling state of WIDTH warps and presents a per-warp ready
//   vector to the downstream issue arbiter. Each warp moves through
//   INACTIVE -> READY -> PIPE -> (MEM_WAIT) -> READY ... -> INACTIVE.
//   A warp issued into the pipeline stays out of the ready set for PIPE_LAT
//   cycles; a load additionally holds it until its memory response returns.
//   Any request that cannot be honoured in the warp's current state is
//   dropped and raises a sticky error flag.
//
// Parameters
//   WIDTH     number of warps tracked (power of two, >= 2)
//   PIPE_LAT  issue-to-ready latency in cycles (1..8)
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high; overrides every other input
//   launch_valid   activate warp launch_warp (must be INACTIVE)
//   launch_warp    index of the warp to activate
//   issue_valid    arbiter issued a warp this cycle
//   issue_oh       one-hot issued warp (arbiter grant)
//   issue_is_mem   issued instruction is a load; warp waits for memory
//   issue_is_exit  issued instruction terminates the warp (beats is_mem)
//   mem_done_valid a memory response returned
//   mem_done_warp  warp owning that response
//   req            per-warp ready vector (registered-state decode only)
//   active_count   number of warps not INACTIVE
//   all_idle       active_count == 0
//   err            sticky protocol-violation flag
//   warp_state_o   debug view of every warp's state, 2 bits per warp,
//                  warp i at [2*i +: 2]; 0=INACTIVE 1=READY 2=PIPE 3=MEM_WAIT
//
// Handshake: every *_valid input is a single-cycle event qualified only by
// its valid bit; there is no ready/backpressure. The block always consumes
// the event on the edge it is presented and reports an illegal one through
// err instead of stalling the sender.
// -----------------------------------------------------------------------------
module warp_ready_table #(
  parameter int WIDTH    = 16,
  parameter int PIPE_LAT = 4,
  localparam int COUNTW  = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                launch_valid,
  input  logic [COUNTW-1:0]   launch_warp,
  input  logic                issue_valid,
  input  logic [WIDTH-1:0]    issue_oh,
  input  logic                issue_is_mem,
  input  logic                issue_is_exit,
  input  logic                mem_done_valid,
  input  logic [COUNTW-1:0]   mem_done_warp,
  output logic [WIDTH-1:0]    req,
  output logic [COUNTW:0]     active_count,
  output logic                all_idle,
  output logic                err,
  output logic [2*WIDTH-1:0]  warp_state_o
);

  typedef enum logic [1:0] {
    W_INACTIVE = 2'd0,
    W_READY    = 2'd1,
    W_PIPE     = 2'd2,
    W_MEM_WAIT = 2'd3
  } warp_state_e;

  // Countdown loaded on issue; the warp leaves PIPE on the cycle the
  // countdown reads zero, giving exactly PIPE_LAT cycles out of the ready set.
  localparam logic [2:0]        PIPE_INIT = 3'(PIPE_LAT - 1);
  localparam logic [WIDTH-1:0]  OH_ONE    = WIDTH'(1);
  localparam logic [COUNTW:0]   CNT_ONE   = (COUNTW+1)'(1);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  warp_state_e       state_q [WIDTH];
  warp_state_e       state_d [WIDTH];
  logic [2:0]        cnt_q   [WIDTH];
  logic [2:0]        cnt_d   [WIDTH];
  logic [WIDTH-1:0]  pend_q;
  logic [WIDTH-1:0]  pend_d;
  logic              err_q;
  logic              err_d;

  // ---------------------------------------------------------------------------
  // Per-warp state class vectors (registered state only)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  inactive_vec;
  logic [WIDTH-1:0]  ready_vec;
  logic [WIDTH-1:0]  pipe_vec;
  logic [WIDTH-1:0]  memwait_vec;

  always_comb begin
    inactive_vec = '0;
    ready_vec    = '0;
    pipe_vec     = '0;
    memwait_vec  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inactive_vec[i] = (state_q[i] == W_INACTIVE);
      ready_vec[i]    = (state_q[i] == W_READY);
      pipe_vec[i]     = (state_q[i] == W_PIPE);
      memwait_vec[i]  = (state_q[i] == W_MEM_WAIT);
    end
  end

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  launch_hit;
  logic [WIDTH-1:0]  mem_hit;
  logic [WIDTH-1:0]  issue_hit;
  logic              issue_nonzero;
  logic              issue_onehot;
  logic              issue_multi;
  logic              launch_bad;
  logic              issue_bad;
  logic              mem_bad;
  logic [WIDTH-1:0]  pend_eff;

  always_comb begin
    launch_hit = '0;
    mem_hit    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      launch_hit[i] = launch_valid   && (launch_warp   == COUNTW'(i));
      mem_hit[i]    = mem_done_valid && (mem_done_warp == COUNTW'(i));
    end
  end

  // x & (x-1) clears the lowest set bit: zero result on a nonzero x means
  // exactly one bit was set.
  assign issue_nonzero = (issue_oh != '0);
  assign issue_multi   = ((issue_oh & (issue_oh - OH_ONE)) != '0);
  assign issue_onehot  = issue_nonzero && !issue_multi;

  // An issue only lands on a READY target; anything else changes no warp.
  assign issue_hit = (issue_valid && issue_onehot) ? (issue_oh & ready_vec) : '0;

  // A memory response arriving while the warp is still in PIPE cancels the
  // pending wait, so the warp leaves PIPE straight to READY.
  assign pend_eff = pend_q & ~mem_hit;

  // Illegal events: launch of a live warp, multi-hot or non-READY issue,
  // memory response for a warp that is not waiting for one. issue_oh == 0
  // is a harmless no-op.
  assign launch_bad = |(launch_hit & ~inactive_vec);
  assign issue_bad  = issue_valid &&
                      (issue_multi || (issue_onehot && ((issue_oh & ready_vec) == '0)));
  assign mem_bad    = |(mem_hit & ~(memwait_vec | (pipe_vec & pend_q)));

  // ---------------------------------------------------------------------------
  // Next-state logic, one FSM per warp
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q | launch_bad | issue_bad | mem_bad;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        W_INACTIVE: begin
          if (launch_hit[i]) begin
            state_d[i] = W_READY;
          end
        end
        W_READY: begin
          if (issue_hit[i]) begin
            if (issue_is_exit) begin
              state_d[i] = W_INACTIVE;
              pend_d[i]  = 1'b0;
            end else begin
              state_d[i] = W_PIPE;
              cnt_d[i]   = PIPE_INIT;
              pend_d[i]  = issue_is_mem;
            end
          end
        end
        W_PIPE: begin
          pend_d[i] = pend_eff[i];
          if (cnt_q[i] == 3'd0) begin
            state_d[i] = pend_eff[i] ? W_MEM_WAIT : W_READY;
            pend_d[i]  = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] - 3'd1;
          end
        end
        W_MEM_WAIT: begin
          if (mem_hit[i]) begin
            state_d[i] = W_READY;
          end
        end
        default: begin
          state_d[i] = W_INACTIVE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= W_INACTIVE;
        cnt_q[i]   <= 3'd0;
      end
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  logic [COUNTW:0] pop_cnt;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!inactive_vec[i]) begin
        pop_cnt = pop_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    warp_state_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      warp_state_o[2*i +: 2] = state_q[i];
    end
  end

  assign req          = ready_vec;
  assign active_count = pop_cnt;
  assign all_idle     = (pop_cnt == '0);
  assign err          = err_q;

endmodule
